// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two Wishbone masters, the memory switch and the arbiter.
// 'master' is the requester/memory side; 'slave' is the arbiter's view.
interface mem_bus_arbiter_if;
  logic        m0_stb_i;
  logic        m1_stb_i;
  logic        m0_we_i;
  logic        m1_we_i;
  logic [31:0] m0_adr_i;
  logic [31:0] m1_adr_i;
  logic [31:0] m0_dat_i;
  logic [31:0] m1_dat_i;
  logic [3:0]  m0_sel_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m0_dat_o;
  logic [31:0] m1_dat_o;
  logic        m0_ack_o;
  logic        m1_ack_o;
  logic        m0_err_o;
  logic        m1_err_o;
  logic        s_cyc_o;
  logic        s_stb_o;
  logic        s_we_o;
  logic [31:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic [1:0]  grant_o;

  modport master (
    output m0_stb_i, m1_stb_i, m0_we_i, m1_we_i, m0_adr_i, m1_adr_i,
           m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i, s_dat_i, s_ack_i,
    input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
           s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, grant_o
  );

  modport slave (
    input  m0_stb_i, m1_stb_i, m0_we_i, m1_we_i, m0_adr_i, m1_adr_i,
           m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i, s_dat_i, s_ack_i,
    output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
           s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, grant_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of the on-chip memory switch.
// Define MEM_BUS_ARB_TIMEOUT_EN to enable the slave-acknowledge watchdog.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t     state;
  logic [1:0] grant;
  logic       last;
  logic       gnt_stb;
  logic       tmo_hit;
  logic       done;
  logic       go0;
  logic       go1;
  logic       drop;

  if (64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_cfg_check
    $error("mem_bus_arbiter: TIMEOUT does not fit in CNT_W bits");
  end

  assign gnt_stb = (grant[0] & bus.m0_stb_i) | (grant[1] & bus.m1_stb_i);
  assign done    = (state != IDLE) & (bus.s_ack_i | tmo_hit);

  // A transaction ending with the other master waiting hands over directly;
  // the master just served is never a candidate on its own ack edge.
  assign go0 = ((state == IDLE) & bus.m0_stb_i & (~bus.m1_stb_i | last)) |
               ((state == GNT1) & done & bus.m0_stb_i);
  assign go1 = ((state == IDLE) & bus.m1_stb_i & (~bus.m0_stb_i | ~last)) |
               ((state == GNT0) & done & bus.m1_stb_i);
  assign drop = (state != IDLE) & (done | ~gnt_stb);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (go0 || go1) begin
      cnt <= '0;
    end else if ((state != IDLE) && !bus.s_ack_i) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tmo_hit = gnt_stb & ~bus.s_ack_i & (cnt == CNT_W'(TIMEOUT));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      grant <= '0;
      last  <= 1'b1;
    end else if (go0) begin
      state <= GNT0;
      grant <= 2'b01;
      last  <= 1'b0;
    end else if (go1) begin
      state <= GNT1;
      grant <= 2'b10;
      last  <= 1'b1;
    end else if (drop) begin
      state <= IDLE;
      grant <= '0;
    end
  end

  assign bus.grant_o = grant;
  assign bus.s_cyc_o = gnt_stb;
  assign bus.s_stb_o = gnt_stb;
  assign bus.s_we_o  = (grant[0] & bus.m0_we_i) | (grant[1] & bus.m1_we_i);
  assign bus.s_adr_o = grant[0] ? bus.m0_adr_i : (grant[1] ? bus.m1_adr_i : '0);
  assign bus.s_dat_o = grant[0] ? bus.m0_dat_i : (grant[1] ? bus.m1_dat_i : '0);
  assign bus.s_sel_o = grant[0] ? bus.m0_sel_i : (grant[1] ? bus.m1_sel_i : '0);

  assign bus.m0_dat_o = grant[0] ? bus.s_dat_i : '0;
  assign bus.m1_dat_o = grant[1] ? bus.s_dat_i : '0;
  assign bus.m0_ack_o = bus.s_ack_i & grant[0];
  assign bus.m1_ack_o = bus.s_ack_i & grant[1];
  assign bus.m0_err_o = tmo_hit & grant[0];
  assign bus.m1_err_o = tmo_hit & grant[1];

endmodule
